// File: rtl/btn_debounce_in.sv
// Push-button input conditioner: synchroniser, stability-counter debounce,
// press/release strobes and a sticky press event with valid/ready handshake.
// Optional LED echo output is enabled by defining BTN_LED_ECHO_EN.
module btn_debounce_in #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic evt_valid_o,
    input  logic evt_ready_i,
    output logic overrun_o
`ifdef BTN_LED_ECHO_EN
    ,
    output logic led_o
`endif
);

    localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic IDLE_PIN = (ACTIVE_LOW != 0);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    state_e                 state_q, state_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   evt_valid_q, evt_valid_d;
    logic                   overrun_q, overrun_d;
    logic                   s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};

    // Polarity-normalised synchronised pin: 1 means pressed.
    assign s = sync_q[SYNC_STAGES-1] ^ IDLE_PIN;

    // Debounce FSM: count consecutive samples that disagree with the state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            RELEASED: begin
                if (s) begin
                    if (cnt_q >= CNT_LAST) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            PRESSED: begin
                if (!s) begin
                    if (cnt_q >= CNT_LAST) begin
                        state_d   = RELEASED;
                        cnt_d     = '0;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
        endcase
    end

    // Sticky press event; a press coinciding with an ack keeps the event alive.
    always_comb begin
        evt_valid_d = press_d | (evt_valid_q & ~evt_ready_i);
        overrun_d   = overrun_q | (press_d & evt_valid_q & ~evt_ready_i);
    end

    // State registers; reset loads the idle pin level into the synchroniser.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q      <= {SYNC_STAGES{IDLE_PIN}};
            cnt_q       <= '0;
            state_q     <= RELEASED;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            evt_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            evt_valid_q <= evt_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign level_o     = (state_q == PRESSED);
    assign press_o     = press_q;
    assign release_o   = release_q;
    assign evt_valid_o = evt_valid_q;
    assign overrun_o   = overrun_q;

`ifdef BTN_LED_ECHO_EN
    logic led_q;

    // Indicator LED echo, one cycle behind the debounced level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_q <= 1'b0;
        end else begin
            led_q <= (state_q == PRESSED);
        end
    end

    assign led_o = led_q;
`endif

endmodule

// File: tb/tb_btn_debounce_in.sv
// Bench for btn_debounce_in: directed scenarios plus random pin activity,
// compared every cycle against a sample-history reference model.
module tb_btn_debounce_in;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic rdy = 1'b0;
    logic level, press, rel, evt_valid, overrun;
`ifdef BTN_LED_ECHO_EN
    logic led;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit pipe[$];
    bit hist[$];
    bit m_lvl, m_press, m_rel, m_ev, m_ov, m_led;

    always #5 clk = ~clk;

    btn_debounce_in #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .ACTIVE_LOW     (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .btn_i       (btn),
        .level_o     (level),
        .press_o     (press),
        .release_o   (rel),
        .evt_valid_o (evt_valid),
        .evt_ready_i (rdy),
        .overrun_o   (overrun)
`ifdef BTN_LED_ECHO_EN
        ,
        .led_o       (led)
`endif
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
    endtask

    // Model one clock edge: the pin value used now is the one that entered
    // the synchroniser SYNC edges ago; the level flips once DEB consecutive
    // synchronised samples disagree with it.
    task automatic model_edge(input bit r, input bit b, input bit a);
        bit pin, want;
        if (r) begin
            pipe.delete();
            for (int i = 0; i < SYNC; i++) pipe.push_back(1'b1);
            hist.delete();
            m_lvl = 0; m_press = 0; m_rel = 0;
            m_ev = 0; m_ov = 0; m_led = 0;
            return;
        end
        m_led = m_lvl;
        pin = pipe.pop_front();
        pipe.push_back(b);
        want = ~pin;
        m_press = 0;
        m_rel = 0;
        if (want == m_lvl) hist.delete();
        else hist.push_back(want);
        if (hist.size() == DEB) begin
            m_lvl = want;
            hist.delete();
            if (want) m_press = 1;
            else m_rel = 1;
        end
        if (m_press) begin
            if (m_ev && !a) m_ov = 1;
            m_ev = 1;
        end else if (a) begin
            m_ev = 0;
        end
    endtask

    task automatic cyc(input bit r, input bit b, input bit a);
        rst = r;
        btn = b;
        rdy = a;
        @(posedge clk);
        model_edge(r, b, a);
        #1;
        check("level", level, m_lvl);
        check("press", press, m_press);
        check("release", rel, m_rel);
        check("evt_valid", evt_valid, m_ev);
        check("overrun", overrun, m_ov);
`ifdef BTN_LED_ECHO_EN
        check("led", led, m_led);
`endif
    endtask

    initial begin
        int presses;
        int tlevel;
        int tlen;
        #2;
        // reset with pin idle, then stay idle
        repeat (3) cyc(1, 1, 0);
        repeat (20) cyc(0, 1, 0);
        // clean press: strobe 6 edges after the transition
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 0, 0);
            check("press_at_edge", press, (i == 6));
        end
        repeat (8) cyc(0, 0, 0);
        // release: strobe 6 edges after the rising pin
        for (int i = 1; i <= 6; i++) begin
            cyc(0, 1, 0);
            check("release_at_edge", rel, (i == 6));
        end
        // short glitches of 1..3 cycles never get accepted
        presses = 0;
        for (int w = 1; w <= 3; w++) begin
            repeat (w) begin cyc(0, 0, 0); presses += press; end
            repeat (5) begin cyc(0, 1, 0); presses += press; end
        end
        check("glitch_no_press", (presses == 0), 1'b1);
        check("glitch_level", level, 1'b0);
        // second press with the first event still pending -> overrun
        repeat (12) cyc(0, 0, 0);
        repeat (12) cyc(0, 1, 0);
        repeat (12) cyc(0, 0, 0);
        check("overrun_set", overrun, 1'b1);
        cyc(0, 0, 1);
        check("ack_clears", evt_valid, 1'b0);
        check("overrun_sticky", overrun, 1'b1);
        repeat (3) cyc(0, 0, 0);
        // reset mid-debounce, button held through it
        cyc(1, 1, 0);
        repeat (6) cyc(0, 1, 0);
        repeat (5) cyc(0, 0, 0);
        cyc(1, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc(0, 0, 0);
            check("press_after_rst", press, (i == 6));
        end
        // random pin activity with sporadic acks and resets
        for (int k = 0; k < 600; k++) begin
            tlevel = $urandom_range(0, 1);
            tlen = $urandom_range(1, 10);
            for (int j = 0; j < tlen; j++)
                cyc(($urandom_range(0, 299) == 0), tlevel[0],
                    ($urandom_range(0, 7) == 0));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
